alu_seq_ctrl: RTL and testbench
===============================

# alu_seq_ctrl

Sequencing controller for the 16-bit combinational ALU (`aluIn`). It accepts a command (opcode plus operand count), pulls operands from a valid/ready stream, and folds each one into an internal accumulator through the ALU. When the run ends it presents the final accumulator as the result and pulses `done`. It sits between an operand source (testbench or upstream FIFO) and the ALU instance; the ALU itself is instantiated outside this block.

## Interface
- `LEN_W`, default 10: width of operand-count field (max run 2^LEN_W−1 operands).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: command strobe; sampled only in IDLE.
- `cmd_op` in 3: ALU opcode for the run; `001` = add.
- `cmd_len` in LEN_W: number of operands in the run.
- `in_valid` in 1: operand valid.
- `in_data` in 16: operand.
- `in_ready` out 1: operand accepted when `in_valid && in_ready`.
- `alu_a` out 16: to ALU `aa`; equals `acc`.
- `alu_b` out 16: to ALU `bb`; equals `in_data`.
- `alu_op` out 3: to ALU `op`; equals registered opcode.
- `alu_y` in 16: ALU `sum` output.
- `busy` out 1: high in LOAD, RUN, DONE.
- `done` out 1: one-cycle pulse; `result` valid.
- `result` out 16: final accumulator; held until next accepted `start`.
- `remain` out LEN_W: operands still to accept.
- `ovf` out 1: sticky add-overflow flag (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, DONE.
- IDLE: `in_ready`=0. On `start`: latch `cmd_op`→`op_reg` and `cmd_len`→`remain`, clear `ovf`. If `cmd_len`=0, go to DONE with `acc`=0. Otherwise go to LOAD.
- LOAD: `in_ready`=1. On accept: `acc`←`in_data` (bypasses the ALU), `remain`−1. If `remain` becomes 0, go to DONE; otherwise go to RUN.
- RUN: `in_ready`=1. On accept: `acc`←`alu_y` (ALU sees `acc`, `in_data`, `op_reg`), `remain`−1. If `remain` becomes 0, go to DONE.
- DONE: `done`=1 and `result`←`acc` for exactly one cycle, then go to IDLE.
- No accept (`in_valid`=0): state and `acc` hold; stalls are unbounded.
- Arithmetic: 16-bit, results wrap modulo 2^16. The accumulator holds whatever the ALU returns; this block never interprets `alu_y`.
- `start` outside IDLE is ignored. `in_valid` in IDLE or DONE is not accepted.

## Timing
- Reset values: state=IDLE, `acc`=0, `op_reg`=0, `remain`=0, `result`=0, `ovf`=0, `done`=0, `busy`=0, `in_ready`=0. `alu_a`=0 and `alu_op`=0.
- `alu_a`, `alu_b`, `alu_op`, and `in_ready` are combinational from registers and input; there are no other combinational input→output paths.
- Latency: with `in_valid` held high, a run of N≥1 operands has `start` at cycle 0, accepts at cycles 1..N, and `done` at cycle N+1. For N=0, `done` is at cycle 1.
- Back-to-back runs: the next `start` can be accepted at cycle N+2, the first IDLE cycle after DONE.
- `rst` during any state forces all reset values at the next edge. Partial accumulation is discarded and `done` does not fire.

## Configuration
- `ALU_SEQ_OVF_EN` defined: on each RUN accept with `op_reg`=`001`, `ovf` is set if the 17-bit sum `{0,acc}+{0,in_data}` has bit 16 set. `ovf` is sticky until the next accepted `start` or `rst`, and is valid alongside `done`.
- Not defined: no overflow logic is compiled; `ovf` is tied to 0.

## Test plan
- Reset: assert `rst` 2 cycles mid-run (after 3 of 5 operands) -> all outputs at reset values, no `done`; a fresh run of len 2 with `1`,`2` and op `001` -> `result`=3.
- Add run: op `001`, len 4, operands 5,3,9,1, `in_valid` held high -> `done` at cycle 5, `result`=18, `remain`=0.
- Stalls: same run with `in_valid` low for 3 cycles between each operand -> `result`=18, `acc` stable during stalls, `done` exactly once.
- Zero length: `start` with `cmd_len`=0 -> `done` at cycle 1, `result`=0, `in_ready` never high.
- Wrap/overflow: op `001`, operands 0xFFFF, 0x0002 -> `result`=0x0001. `ovf`=1 with `ALU_SEQ_OVF_EN`, 0 without.
- Ignored start: pulse `start` with len 7 during RUN of a len-2 run -> original run completes with its own op and length; `busy` drops after DONE.

Source files
------------

// File: rtl/alu_seq_ctrl.sv
// Purpose : sequences operands from a valid/ready stream through an external 16-bit ALU into an accumulator.
// Latency : N>=1 operands with in_valid held high -> done N+1 cycles after start; N=0 -> done 1 cycle after start.
// Backpr. : in_ready high only in LOAD/RUN; stalls (in_valid low) hold state and acc indefinitely.
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   start, cmd_op,      command strobe (sampled only in IDLE), opcode for the run,
//   cmd_len             number of operands in the run
//   in_valid, in_data,  operand stream; an operand is taken when in_valid && in_ready
//   in_ready
//   alu_a, alu_b,       drive the external ALU: alu_a = acc, alu_b = in_data, alu_op = latched opcode
//   alu_op, alu_y       alu_y is the ALU result fed back into acc
//   busy, done, result  busy in LOAD/RUN/DONE; done pulses one cycle with result valid
//   remain              operands still to accept
//   ovf                 sticky 16-bit add overflow flag
//
// Optional feature: define ALU_SEQ_OVF_EN to compile the overflow detector; otherwise ovf is tied low.

module alu_seq_ctrl #(
  parameter int LEN_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             in_valid,
  input  logic [15:0]      in_data,
  output logic             in_ready,
  output logic [15:0]      alu_a,
  output logic [15:0]      alu_b,
  output logic [2:0]       alu_op,
  input  logic [15:0]      alu_y,
  output logic             busy,
  output logic             done,
  output logic [15:0]      result,
  output logic [LEN_W-1:0] remain,
  output logic             ovf
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t      state;
  logic [15:0] acc;
  logic [2:0]  op_reg;
  logic        accept;
  logic        last;

  assign in_ready = (state == S_LOAD) || (state == S_RUN);
  assign accept   = in_valid && in_ready;
  // The operand being accepted now is the final one of the run.
  assign last     = (remain == LEN_W'(1));

  assign alu_a  = acc;
  assign alu_b  = in_data;
  assign alu_op = op_reg;

  // result is loaded on the edge that enters DONE so it is already valid
  // during the done cycle, and then held until the next run completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      op_reg <= '0;
      remain <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            op_reg <= cmd_op;
            remain <= cmd_len;
            acc    <= '0;
            busy   <= 1'b1;
            if (cmd_len == '0) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= '0;
            end else begin
              state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          if (accept) begin
            // First operand bypasses the ALU.
            acc    <= in_data;
            remain <= remain - LEN_W'(1);
            if (last) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= in_data;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (accept) begin
            acc    <= alu_y;
            remain <= remain - LEN_W'(1);
            if (last) begin
              state  <= S_DONE;
              done   <= 1'b1;
              result <= alu_y;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_OVF_EN
  // Carry-out of an unsigned 16-bit add of acc and in_data.
  logic [16:0] add17;
  assign add17 = {1'b0, acc} + {1'b0, in_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if ((state == S_IDLE) && start) begin
      ovf <= 1'b0;
    end else if ((state == S_RUN) && accept && (op_reg == 3'b001) && add17[16]) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Purpose : bench for alu_seq_ctrl with a behavioural ALU closing the loop on alu_y.
// Latency : n/a (bench).
// Backpr. : drives in_valid with programmable stall gaps between operands.

module tb_alu_seq_ctrl;
  localparam int LEN_W = 10;

`ifdef ALU_SEQ_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [2:0]       cmd_op;
  logic [LEN_W-1:0] cmd_len;
  logic             in_valid;
  logic [15:0]      in_data;
  logic             in_ready;
  logic [15:0]      alu_a;
  logic [15:0]      alu_b;
  logic [2:0]       alu_op;
  logic [15:0]      alu_y;
  logic             busy;
  logic             done;
  logic [15:0]      result;
  logic [LEN_W-1:0] remain;
  logic             ovf;

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
    case (op)
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a ^ b;
      default: return a | b;
    endcase
  endfunction

  assign alu_y = alu_f(alu_a, alu_b, alu_op);

  alu_seq_ctrl #(.LEN_W(LEN_W)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .cmd_op  (cmd_op),
    .cmd_len (cmd_len),
    .in_valid(in_valid),
    .in_data (in_data),
    .in_ready(in_ready),
    .alu_a   (alu_a),
    .alu_b   (alu_b),
    .alu_op  (alu_op),
    .alu_y   (alu_y),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .remain  (remain),
    .ovf     (ovf)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_busy"},     busy,     0);
    chk({tag, "_done"},     done,     0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_remain"},   remain,   0);
    chk({tag, "_result"},   result,   0);
    chk({tag, "_alu_a"},    alu_a,    0);
    chk({tag, "_alu_op"},   alu_op,   0);
    chk({tag, "_ovf"},      ovf,      0);
  endtask

  typedef struct {
    logic [2:0]        op;
    int                len;
    int                stall;    // in_valid-low cycles after each accepted operand
    logic [3:0][15:0]  d;
    logic [15:0]       res;
    int                exp_done; // cycle of done, start at cycle 0
    bit                ovf;      // 17-bit add overflow occurred in a RUN accept
  } vec_t;

  vec_t vecs[8];

  task automatic set_vec(input int i, input logic [2:0] op, input int len, input int stall,
                         input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic [15:0] d3,
                         input logic [15:0] res, input int exp_done, input bit ov);
    vecs[i].op       = op;
    vecs[i].len      = len;
    vecs[i].stall    = stall;
    vecs[i].d        = {d3, d2, d1, d0};
    vecs[i].res      = res;
    vecs[i].exp_done = exp_done;
    vecs[i].ovf      = ov;
  endtask

  task automatic run_vec(input int i);
    vec_t        v;
    int          cyc;
    int          k;
    int          gap;
    int          done_cyc;
    bit          saw_rdy;
    logic [15:0] macc;
    v = vecs[i];
    tick();
    start    = 1'b1;
    cmd_op   = v.op;
    cmd_len  = LEN_W'(v.len);
    in_valid = (v.len > 0) && (v.stall == 0);
    in_data  = v.d[0];
    cyc = 0; k = 0; gap = 0; done_cyc = -1; saw_rdy = 1'b0; macc = '0;
    while (done_cyc < 0 && cyc < 300) begin
      tick();
      start   = 1'b0;
      cmd_len = LEN_W'(7);
      cyc++;
      if (gap > 0) begin
        in_valid = 1'b0;
        gap--;
      end else if (k < v.len) begin
        in_valid = 1'b1;
        in_data  = v.d[k];
      end else begin
        in_valid = 1'b0;
      end
      smp();
      if (in_ready) begin
        saw_rdy = 1'b1;
        chk($sformatf("v%0d_acc_c%0d", i, cyc), alu_a, macc);
      end
      if (done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d_result", i), result, v.res);
        chk($sformatf("v%0d_remain", i), remain, 0);
        chk($sformatf("v%0d_ovf", i),    ovf,    v.ovf & OVF_ON);
        chk($sformatf("v%0d_busy_done", i), busy, 1);
      end else if (in_valid && in_ready) begin
        macc = (k == 0) ? in_data : alu_f(macc, in_data, v.op);
        k++;
        gap = v.stall;
      end
    end
    chk($sformatf("v%0d_done_cycle", i), done_cyc, v.exp_done);
    chk($sformatf("v%0d_saw_ready", i), saw_rdy, (v.len > 0));
    tick();
    in_valid = 1'b0;
    smp();
    chk($sformatf("v%0d_done_once", i), done,   0);
    chk($sformatf("v%0d_busy_idle", i), busy,   0);
    chk($sformatf("v%0d_res_held", i),  result, v.res);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; cmd_op = '0; cmd_len = '0; in_valid = 1'b0; in_data = '0;

    //            op      len stall d0       d1       d2       d3     result   done ovf
    set_vec(0, 3'b001, 4, 0, 16'd5,   16'd3,   16'd9,   16'd1, 16'd18,   5,  0);
    set_vec(1, 3'b001, 4, 3, 16'd5,   16'd3,   16'd9,   16'd1, 16'd18,   14, 0);
    set_vec(2, 3'b001, 0, 0, 16'd0,   16'd0,   16'd0,   16'd0, 16'd0,    1,  0);
    set_vec(3, 3'b001, 2, 0, 16'hFFFF, 16'h0002, 16'd0,  16'd0, 16'h0001, 3,  1);
    set_vec(4, 3'b001, 1, 0, 16'h1234, 16'd0,   16'd0,   16'd0, 16'h1234, 2,  0);
    set_vec(5, 3'b001, 3, 1, 16'hFFFF, 16'h0001, 16'h0001, 16'd0, 16'h0001, 6, 1);
    set_vec(6, 3'b010, 3, 0, 16'd100, 16'd30,  16'd7,   16'd0, 16'd63,   4,  0);
    set_vec(7, 3'b001, 2, 0, 16'd1,   16'd2,   16'd0,   16'd0, 16'd3,    3,  0);

    repeat (3) tick();
    smp();
    check_reset("por");
    tick();
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(i);

    // Reset after 3 of 5 operands: run is abandoned, no done.
    tick(); start = 1'b1; cmd_op = 3'b001; cmd_len = LEN_W'(5); in_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick(); start = 1'b0; in_valid = 1'b1; in_data = 16'(c);
      smp(); chk($sformatf("rstrun_nodone_c%0d", c), done, 0);
    end
    tick(); rst = 1'b1; in_data = 16'd4;
    smp(); chk("rstrun_nodone_c4", done, 0);
    tick();
    smp(); check_reset("rst1");
    tick(); rst = 1'b0; in_valid = 1'b0;
    smp(); check_reset("rst2");
    run_vec(7);

    // start during RUN is ignored; then back-to-back zero-length run at N+2.
    tick(); start = 1'b1; cmd_op = 3'b001; cmd_len = LEN_W'(2); in_valid = 1'b0;
    tick(); start = 1'b0; in_valid = 1'b1; in_data = 16'd10;
    smp(); chk("ign_load_ready", in_ready, 1);
    tick(); in_valid = 1'b0; start = 1'b1; cmd_op = 3'b010; cmd_len = LEN_W'(7);
    smp(); chk("ign_remain_c2", remain, 1); chk("ign_op_c2", alu_op, 3'b001); chk("ign_acc_c2", alu_a, 10);
    tick(); start = 1'b0; in_valid = 1'b1; in_data = 16'd20;
    smp(); chk("ign_remain_c3", remain, 1); chk("ign_op_c3", alu_op, 3'b001);
    tick(); in_valid = 1'b0;
    smp(); chk("ign_done", done, 1); chk("ign_result", result, 30); chk("ign_busy_done", busy, 1);
    chk("ign_remain_done", remain, 0);
    tick(); start = 1'b1; cmd_op = 3'b001; cmd_len = '0;
    smp(); chk("ign_busy_idle", busy, 0); chk("ign_done_idle", done, 0);
    tick(); start = 1'b0;
    smp(); chk("b2b_done", done, 1); chk("b2b_result", result, 0); chk("b2b_ready", in_ready, 0);
    tick();
    smp(); chk("b2b_done_once", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
